// File: rtl/tt_mux_sel_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tt_mux_sel_ctrl
// Description : Project-select address/enable controller for the spine mux.
//               Synchronizes the external select pins and gaps the enable
//               around every address change.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_mux_sel_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_rst_n_pin,
    input  logic              sel_inc_pin,
    output logic [ADDR_W-1:0] spine_sel_addr,
    output logic              spine_sel_ena,
    output logic              busy
);

    localparam int                 CNT_W        = 8;
    localparam logic [CNT_W-1:0]   c_settle_load = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0]   c_cnt_one     = CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_addr_one    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2
    } state_t;

    logic              r_rst_s1;
    logic              r_rst_s2;
    logic              r_inc_s1;
    logic              r_inc_s2;
    logic              r_inc_d;
    logic              w_inc_evt;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_ena;
    logic              w_ena_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    // Both pins are asynchronous; the select-reset side idles high so a
    // controller reset does not look like a pin reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_s1 <= 1'b1;
            r_rst_s2 <= 1'b1;
            r_inc_s1 <= 1'b0;
            r_inc_s2 <= 1'b0;
            r_inc_d  <= 1'b0;
        end else begin
            r_rst_s1 <= sel_rst_n_pin;
            r_rst_s2 <= r_rst_s1;
            r_inc_s1 <= sel_inc_pin;
            r_inc_s2 <= r_inc_s1;
            r_inc_d  <= r_inc_s2;
        end
    end

    assign w_inc_evt = r_inc_s2 & ~r_inc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SETTLE;
            r_cnt   <= c_settle_load;
            r_addr  <= '0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_ena   <= w_ena_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_ena_nxt   = r_ena;

        if (!r_rst_s2) begin
            // Pin reset dominates; increment events are dropped here.
            w_state_nxt = ST_HOLD;
            w_addr_nxt  = '0;
            w_ena_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = c_settle_load;
                end
                ST_SETTLE: begin
                    if (w_inc_evt) begin
                        w_addr_nxt = r_addr + c_addr_one;
                        w_ena_nxt  = 1'b0;
                        w_cnt_nxt  = c_settle_load;
                    end else if (r_cnt <= c_cnt_one) begin
                        w_state_nxt = ST_ON;
                        w_ena_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                ST_ON: begin
                    // Address and enable drop on the same edge so the spine
                    // never sees a new address while enabled.
                    if (w_inc_evt) begin
                        w_state_nxt = ST_SETTLE;
                        w_addr_nxt  = r_addr + c_addr_one;
                        w_ena_nxt   = 1'b0;
                        w_cnt_nxt   = c_settle_load;
                    end
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_ena_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign w_busy_nxt = (w_state_nxt != ST_ON);

    assign spine_sel_addr = r_addr;
    assign spine_sel_ena  = r_ena;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: doc/tt_mux_sel_ctrl.md
TT_MUX_SEL_CTRL -- requirements
Module: tt_mux_sel_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the project-select address.
REQ-002 SHALL have parameter SETTLE_CYC, default 4, legal range 1..255: cycles the select enable stays low after any address change.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sel_rst_n_pin  input  1  external select-reset pin, asynchronous to clk, active-low.
REQ-006 SHALL have port sel_inc_pin  input  1  external select-increment pin, asynchronous to clk, rising-edge meaningful.
REQ-007 SHALL have port spine_sel_addr  output  ADDR_W  registered select address, driven into the high-drive spine buffer.
REQ-008 SHALL have port spine_sel_ena  output  1  registered select enable, driven into the high-drive spine buffer.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in ON.

Function
REQ-010 SHALL pass each pin through a 2-flop synchronizer (s1, s2).
REQ-011 SHALL hold a third flop, inc_d, for sel_inc.
REQ-012 SHALL detect an increment event when inc s2=1 and inc_d=0.
REQ-013 SHALL implement FSM states HOLD, SETTLE and ON.
REQ-014 SHALL, in any state, when synced sel_rst_n s2=0: load addr=0 and ena=0, enter HOLD, and ignore increment events.
REQ-015 SHALL, in HOLD with s2=1, enter SETTLE with settle counter loaded to SETTLE_CYC.
REQ-016 SHALL, in SETTLE, decrement the counter each cycle, then enter ON and set ena=1 on the cycle the counter would reach 0.
REQ-017 SHALL, on an increment event in ON or SETTLE: set addr=addr+1 modulo 2^ADDR_W, set ena=0 on the same edge, enter SETTLE, and reload the counter to SETTLE_CYC.
REQ-018 SHALL treat a reload in SETTLE as restarting the full settle window.
REQ-019 SHALL wrap addr from 2^ADDR_W-1 to 0, with ena gapping the same as any other increment.
REQ-020 SHALL NOT let an address change occur while ena=1: addr and ena=0 update on the same edge.
REQ-021 SHALL give sel_rst_n priority when it coincides with an increment event; addr becomes 0.
REQ-022 SHALL, for sel_inc_pin first sampled high at edge N, change addr at edge N+2 and raise ena at edge N+2+SETTLE_CYC, absent further events.
REQ-023 SHALL, for sel_rst_n_pin first sampled low at edge N, force addr=0 and ena=0 at edge N+2.
REQ-024 SHALL drive spine_sel_addr, spine_sel_ena and busy directly from flops, with no combinational path from the pins.
REQ-025 SHALL count at most one increment per inc pin rising edge, regardless of high-pulse length.

Reset
REQ-026 SHALL, on clk edge with rst_n=0, set: addr=0, ena=0, busy=1, state=SETTLE, counter=SETTLE_CYC.
REQ-027 SHALL reset the sel_rst_n synchronizer flops to 1.
REQ-028 SHALL reset the sel_inc synchronizer flops and inc_d to 0.
REQ-029 SHALL, after rst_n release with pins idle, raise ena at SETTLE_CYC edges after the first edge with rst_n=1.
REQ-030 SHALL let rst_n=0 mid-SETTLE or mid-increment override all other activity on that edge.

Verification
REQ-031 Reset release, pins idle, SETTLE_CYC=4 -> addr=0, ena rises on 4th edge after release, busy falls with it.
REQ-032 Three inc pulses spaced 10 cycles apart -> addr steps 0->1->2->3; each step has ena=0 for exactly 4 cycles, starting on the addr-change edge.
REQ-033 Inc pulse at addr=1023, ADDR_W=10 -> addr=0, ena low 4 cycles, then high.
REQ-034 Second inc edge 2 cycles into SETTLE -> addr increments again; ena stays low 4 cycles from the second change.
REQ-035 sel_rst_n_pin low at addr=37 while inc rises in the same cycle -> addr=0, ena=0 two edges later, busy=1; ena returns 4 cycles after the pin is synced high.
REQ-036 Inc held high 50 cycles -> exactly one increment.
